// File: rtl/byte_serializer.sv
// Parallel-to-serial word shifter with optional even-parity bit and a frame counter.
// A new word can be taken on the final bit of a frame, so back-to-back frames have no gap.
module byte_serializer #(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter int   PARITY    = 0,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  output logic             out_last,
  output logic [7:0]       word_count
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] PENULT_IDX = CNT_W'(WIDTH - 2);

  typedef enum logic [1:0] {IDLE, DATA, PAR} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
  logic             parity_reg, parity_next;
  logic             out_bit_reg, out_bit_next;
  logic             out_valid_reg, out_valid_next;
  logic             out_last_reg, out_last_next;
  logic [7:0]       count_reg, count_next;

  logic             load_first, next_bit;
  logic [WIDTH-1:0] load_shift, shift_adv;
  logic             last_data, frame_end, accept;

  // The shift register holds only the bits not yet shown; the first bit goes straight to out_bit.
  generate
    if (MSB_FIRST != 0) begin : g_msb
      assign load_first = in_data[WIDTH-1];
      assign load_shift = in_data << 1;
      assign next_bit   = shift_reg[WIDTH-1];
      assign shift_adv  = shift_reg << 1;
    end else begin : g_lsb
      assign load_first = in_data[0];
      assign load_shift = in_data >> 1;
      assign next_bit   = shift_reg[0];
      assign shift_adv  = shift_reg >> 1;
    end
  endgenerate

  always_comb begin
    last_data = (state_reg == DATA) && (bit_cnt_reg == LAST_IDX);
    frame_end = (state_reg == PAR) || (last_data && (PARITY == 0));
    in_ready  = !reset && ((state_reg == IDLE) || frame_end);
    accept    = in_valid && in_ready;
  end

  always_comb begin
    state_next     = state_reg;
    shift_next     = shift_reg;
    bit_cnt_next   = bit_cnt_reg;
    parity_next    = parity_reg;
    out_bit_next   = out_bit_reg;
    out_valid_next = out_valid_reg;
    out_last_next  = out_last_reg;
    count_next     = count_reg;

    case (state_reg)
      IDLE: ;
      DATA: begin
        if (!last_data) begin
          out_bit_next  = next_bit;
          shift_next    = shift_adv;
          bit_cnt_next  = bit_cnt_reg + 1'b1;
          out_last_next = (PARITY == 0) && (bit_cnt_reg == PENULT_IDX);
        end else if (PARITY != 0) begin
          state_next    = PAR;
          out_bit_next  = parity_reg;
          out_last_next = 1'b1;
        end
      end
      PAR: ;
      default: state_next = IDLE;
    endcase

    if (frame_end) begin
      count_next     = count_reg + 8'd1;
      state_next     = IDLE;
      out_valid_next = 1'b0;
      out_last_next  = 1'b0;
      out_bit_next   = IDLE_BIT;
    end

    // Accept overrides the frame-end return to IDLE so the next word follows without a gap.
    if (accept) begin
      state_next     = DATA;
      shift_next     = load_shift;
      bit_cnt_next   = '0;
      parity_next    = ^in_data;
      out_bit_next   = load_first;
      out_valid_next = 1'b1;
      out_last_next  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      shift_reg     <= '0;
      bit_cnt_reg   <= '0;
      parity_reg    <= 1'b0;
      out_bit_reg   <= IDLE_BIT;
      out_valid_reg <= 1'b0;
      out_last_reg  <= 1'b0;
      count_reg     <= 8'd0;
    end else begin
      state_reg     <= state_next;
      shift_reg     <= shift_next;
      bit_cnt_reg   <= bit_cnt_next;
      parity_reg    <= parity_next;
      out_bit_reg   <= out_bit_next;
      out_valid_reg <= out_valid_next;
      out_last_reg  <= out_last_next;
      count_reg     <= count_next;
    end
  end

  assign out_bit    = out_bit_reg;
  assign out_valid  = out_valid_reg;
  assign out_last   = out_last_reg;
  assign word_count = count_reg;

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer: three configurations checked every cycle against a bit-queue model,
// plus literal expectations for the directed frames.
module tb_byte_serializer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [2:0] iv, rdy, ob, ov, ol;
  logic [7:0] idat [3];
  logic [7:0] wc   [3];

  // Instance 0: MSB first, no parity. 1: MSB first, parity. 2: LSB first, idle level 1.
  localparam bit MSB_P  [3] = '{1'b1, 1'b1, 1'b0};
  localparam bit PAR_P  [3] = '{1'b0, 1'b1, 1'b0};
  localparam bit IDLE_B [3] = '{1'b0, 1'b0, 1'b1};

  byte_serializer #(.WIDTH(8), .MSB_FIRST(1), .PARITY(0), .IDLE_BIT(1'b0)) u_a (
    .clk(clk), .reset(rst), .in_data(idat[0]), .in_valid(iv[0]), .in_ready(rdy[0]),
    .out_bit(ob[0]), .out_valid(ov[0]), .out_last(ol[0]), .word_count(wc[0]));
  byte_serializer #(.WIDTH(8), .MSB_FIRST(1), .PARITY(1), .IDLE_BIT(1'b0)) u_b (
    .clk(clk), .reset(rst), .in_data(idat[1]), .in_valid(iv[1]), .in_ready(rdy[1]),
    .out_bit(ob[1]), .out_valid(ov[1]), .out_last(ol[1]), .word_count(wc[1]));
  byte_serializer #(.WIDTH(8), .MSB_FIRST(0), .PARITY(0), .IDLE_BIT(1'b1)) u_c (
    .clk(clk), .reset(rst), .in_data(idat[2]), .in_valid(iv[2]), .in_ready(rdy[2]),
    .out_bit(ob[2]), .out_valid(ov[2]), .out_last(ol[2]), .word_count(wc[2]));

  int checks = 0;
  int failures = 0;

  // Model: per instance, the bits of the current frame still to be shown (front = on the wire now).
  bit   mq [3][$];
  int   mcnt [3];
  bit   started = 1'b0;
  bit   acc_v [3];
  logic [7:0] w_tmp;

  logic [63:0] rec [3];
  int          rec_n [3];
  int          last_n [3];

  function automatic bit m_ready(int i);
    return !rst && (mq[i].size() <= 1);
  endfunction

  task automatic chk(string name, int i, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d]: got %0h expected %0h at %0t", name, i, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) acc_v[i] = m_ready(i) && iv[i];
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        mq[i].delete();
        mcnt[i] = 0;
      end else begin
        if (mq[i].size() > 0) begin
          mq[i].delete(0);
          if (mq[i].size() == 0) mcnt[i] = (mcnt[i] + 1) % 256;
        end
        if (acc_v[i]) begin
          w_tmp = idat[i];
          for (int k = 0; k < 8; k++) mq[i].push_back(MSB_P[i] ? w_tmp[7-k] : w_tmp[k]);
          if (PAR_P[i]) mq[i].push_back(^w_tmp);
        end
      end
    end
    if (rst) started = 1'b1;
  end

  bit e_v, e_b, e_l;
  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 3; i++) begin
        e_v = mq[i].size() > 0;
        e_b = e_v ? mq[i][0] : IDLE_B[i];
        e_l = mq[i].size() == 1;
        chk("out_valid", i, 32'(ov[i]), 32'(e_v));
        chk("out_bit", i, 32'(ob[i]), 32'(e_b));
        chk("out_last", i, 32'(ol[i]), 32'(e_l));
        chk("in_ready", i, 32'(rdy[i]), 32'(m_ready(i)));
        chk("word_count", i, 32'(wc[i]), 32'(mcnt[i]));
        if (ov[i] === 1'b1) begin
          rec[i] = {rec[i][62:0], ob[i]};
          rec_n[i]++;
          if (ol[i] === 1'b1) last_n[i]++;
        end
      end
    end
  end

  task automatic idle(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  task automatic clear_rec();
    for (int i = 0; i < 3; i++) begin
      rec[i] = '0;
      rec_n[i] = 0;
      last_n[i] = 0;
    end
  endtask

  task automatic send(int i, logic [7:0] w, bit keep);
    bit acc;
    iv[i] = 1'b1;
    idat[i] = w;
    for (int n = 0; n < 100; n++) begin
      acc = m_ready(i);
      @(posedge clk);
      #1;
      if (acc) begin
        if (!keep) iv[i] = 1'b0;
        return;
      end
    end
    failures++;
    $display("FAIL send_timeout[%0d]: word %0h not accepted within 100 cycles", i, w);
    iv[i] = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int accepted;
    bit will_acc;
    rst = 1'b1;
    iv = '0;
    for (int i = 0; i < 3; i++) idat[i] = '0;
    clear_rec();
    idle(2);
    rst = 1'b0;
    chk("reset_wc", 0, 32'(wc[0]), 0);
    chk("reset_ov", 1, 32'(ov[1]), 0);
    chk("reset_idle_bit", 2, 32'(ob[2]), 1);

    // Single word, MSB first.
    clear_rec();
    send(0, 8'hC3, 0);
    idle(12);
    chk("c3_nbits", 0, rec_n[0], 8);
    chk("c3_bits", 0, 32'(rec[0][7:0]), 'hC3);
    chk("c3_lasts", 0, last_n[0], 1);
    chk("c3_wc", 0, 32'(wc[0]), 1);
    chk("c3_idle", 0, 32'(ov[0]), 0);

    // Back-to-back words with in_valid held.
    do_reset();
    clear_rec();
    send(0, 8'hF0, 1);
    send(0, 8'h0F, 0);
    idle(20);
    chk("b2b_nbits", 0, rec_n[0], 16);
    chk("b2b_bits", 0, 32'(rec[0][15:0]), 'hF00F);
    chk("b2b_lasts", 0, last_n[0], 2);
    chk("b2b_wc", 0, 32'(wc[0]), 2);

    // Parity: 07 -> parity 1, A5 -> parity 0, second word taken during the parity cycle.
    do_reset();
    clear_rec();
    send(1, 8'h07, 1);
    send(1, 8'hA5, 0);
    idle(22);
    chk("par_nbits", 1, rec_n[1], 18);
    chk("par_bits", 1, 32'(rec[1][17:0]), 32'({8'h07, 1'b1, 8'hA5, 1'b0}));
    chk("par_lasts", 1, last_n[1], 2);
    chk("par_wc", 1, 32'(wc[1]), 2);

    // LSB first: first bit on the wire is bit 0.
    do_reset();
    clear_rec();
    send(2, 8'h01, 0);
    idle(12);
    chk("lsb_nbits", 2, rec_n[2], 8);
    chk("lsb_bits", 2, 32'(rec[2][7:0]), 'h80);
    chk("lsb_idle_bit", 2, 32'(ob[2]), 1);

    // Reset during the 4th bit of AA aborts the frame.
    do_reset();
    clear_rec();
    send(0, 8'hAA, 0);
    idle(3);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("abort_ov", 0, 32'(ov[0]), 0);
    chk("abort_ob", 0, 32'(ob[0]), 0);
    chk("abort_wc", 0, 32'(wc[0]), 0);
    chk("abort_bits", 0, 32'(rec[0][3:0]), 'hA);
    chk("abort_nbits", 0, rec_n[0], 4);
    send(0, 8'hFF, 0);
    idle(12);
    chk("after_abort_nbits", 0, rec_n[0], 12);
    chk("after_abort_bits", 0, 32'(rec[0][7:0]), 'hFF);
    chk("after_abort_wc", 0, 32'(wc[0]), 1);

    // 256 gapless frames with junk on in_valid/in_data while not ready.
    do_reset();
    clear_rec();
    accepted = 0;
    for (int n = 0; n < 4000 && accepted < 256; n++) begin
      if (m_ready(0)) begin
        iv[0] = 1'b1;
        idat[0] = 8'(accepted) ^ 8'h5A;
      end else begin
        iv[0] = 1'($urandom);
        idat[0] = 8'($urandom);
      end
      will_acc = m_ready(0) && iv[0];
      @(posedge clk);
      #1;
      if (will_acc) accepted++;
    end
    iv[0] = 1'b0;
    chk("wrap_accepts", 0, accepted, 256);
    chk("wrap_wc255", 0, 32'(wc[0]), 255);
    idle(12);
    chk("wrap_wc0", 0, 32'(wc[0]), 0);
    chk("wrap_lasts", 0, last_n[0], 256);
    chk("wrap_nbits", 0, rec_n[0], 2048);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/byte_serializer.md
BYTE_SERIALIZER -- requirements
Module: byte_serializer

Interface
REQ-001 WIDTH, 8, data word width in bits (legal 2..32).
REQ-002 MSB_FIRST, 1, 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
REQ-003 PARITY, 0, 0 = no parity bit; 1 = one even-parity bit is appended after the data bits.
REQ-004 IDLE_BIT, 0, value driven on out_bit when no word is being sent.
REQ-005 clk  input  1  single clock; all logic is rising-edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 in_data  input  WIDTH  parallel word, sampled on accept.
REQ-008 in_valid  input  1  in_data is valid this cycle.
REQ-009 in_ready  output  1  block can accept a word this cycle; combinational from state and counter.
REQ-010 out_bit  output  1  registered serial bit, one bit per clock; feeds the pair detector's serial input.
REQ-011 out_valid  output  1  registered; out_bit carries a data or parity bit.
REQ-012 out_last  output  1  registered; high during the final bit of a frame (the parity bit if PARITY=1).
REQ-013 word_count  output  8  registered count of completed frames; wraps 255 -> 0.

Function
REQ-014 The design SHALL have exactly three states: IDLE, DATA and PAR.
REQ-015 Accept SHALL occur at a rising edge where in_valid=1, in_ready=1 and reset=0; no other edge loads in_data.
REQ-016 in_ready SHALL be 1 in IDLE, 1 in DATA on the final data bit when PARITY=0, 1 in PAR, and 0 in all other cycles.
REQ-017 in_ready SHALL be 0 in every cycle where reset=1.
REQ-018 Accept SHALL load a shift register, clear the bit counter, and fold in_data into a running XOR for parity.
REQ-019 Accept SHALL enter DATA with out_valid=1 and out_bit set to the first bit, both visible in the cycle after the accept edge (latency 1).
REQ-020 In DATA, each edge SHALL advance exactly one bit; data bits appear on WIDTH consecutive cycles with no gaps.
REQ-021 With PARITY=1, the edge that ends the last data bit SHALL enter PAR and drive out_bit = XOR of all data bits for one cycle.
REQ-022 out_last SHALL be 1 only during the final bit of a frame.
REQ-023 word_count SHALL increment by 1 at the edge that ends each frame's final bit.
REQ-024 At a frame end with in_valid=1 (accept), the next frame's first bit SHALL follow the prior final bit in the very next cycle, with out_valid staying 1 and no idle cycle.
REQ-025 At a frame end with in_valid=0, the block SHALL enter IDLE with out_valid=0, out_last=0 and out_bit=IDLE_BIT.
REQ-026 in_data and in_valid changes while in_ready=0 SHALL have no effect; the word in flight is never corrupted.
REQ-027 In IDLE, out_bit SHALL hold IDLE_BIT and out_valid SHALL be 0.
REQ-028 Frame length SHALL be WIDTH + PARITY cycles.
REQ-029 The bit counter SHALL be wide enough for WIDTH-1 and SHALL never wrap within a frame.

Reset
REQ-030 At any edge with reset=1, the block SHALL set: state=IDLE, out_bit=IDLE_BIT, out_valid=0, out_last=0, word_count=0, bit counter=0, shift register=0.
REQ-031 Reset asserted mid-frame SHALL abort the frame immediately: no further bits, no word_count increment, and no accept at that edge.
REQ-032 The first accept after reset SHALL be possible at the first edge with reset=0.

Verification
REQ-033 WIDTH=8, MSB_FIRST=1, PARITY=0; single accept of 8'hC3 -> out_bit 1,1,0,0,0,0,1,1 on 8 consecutive cycles; out_last only on the 8th; in_ready=0 on cycles 1-7; word_count 0->1; then out_valid=0.
REQ-034 Back-to-back 8'hF0 then 8'h0F with in_valid held high -> 16 contiguous valid bits 11110000 00001111; exactly two out_last pulses; word_count=2.
REQ-035 PARITY=1, word 8'h07 -> 9 bits 00000111 then parity 1; in_ready high only in the PAR cycle; next word accepted in PAR follows gaplessly.
REQ-036 MSB_FIRST=0, word 8'h01 -> out_bit 1,0,0,0,0,0,0,0.
REQ-037 Reset pulsed on the 4th bit of 8'hAA -> next cycle out_valid=0, out_bit=IDLE_BIT, word_count=0; a new word 8'hFF afterwards -> 8 ones.
REQ-038 256 consecutive frames -> word_count wraps to 0; in_valid toggled while in_ready=0 -> bit stream unchanged.
